// File: rtl/trace_checker.sv
// Lockstep commit checker: stalls the CPU on each retired instruction and
// compares pc, inst and the whole register file against a 34-word record.
module trace_checker #(
    parameter int MAX_RECORDS = 1200,
    parameter int STOP_ON_ERR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    output logic        cpu_stall,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    input  logic        exp_valid,
    input  logic [31:0] exp_data,
    output logic        exp_ready,
    output logic        mismatch,
    output logic [15:0] err_count,
    output logic [15:0] rec_count,
    output logic [15:0] first_err_rec,
    output logic [5:0]  first_err_field,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [15:0] MAX_REC16 = 16'(MAX_RECORDS);
    localparam logic [5:0]  LAST_FIELD = 6'd33;

    state_e      state_q, state_d;
    logic [5:0]  field_q, field_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        mismatch_q, mismatch_d;
    logic [15:0] err_q, err_d;
    logic [15:0] rec_q, rec_d;
    logic [15:0] ferr_rec_q, ferr_rec_d;
    logic [5:0]  ferr_fld_q, ferr_fld_d;
    logic        done_q, done_d;

    logic        fire;
    logic        last_fire;
    logic        field_bad;
    logic [31:0] cmp_word;
    logic [15:0] rec_inc;
    logic        hit_limit;
    logic        stop_now;

    // A field is consumed only when the checker is in CHECK and a word is offered
    assign fire      = (state_q == S_CHECK) && exp_valid;
    assign last_fire = fire && (field_q == LAST_FIELD);
    assign rec_inc   = rec_q + 16'd1;
    assign hit_limit = (rec_inc == MAX_REC16);

    always_comb begin
        cmp_word = rf_rdata;
        if (field_q == 6'd0) begin
            cmp_word = pc_q;
        end else if (field_q == 6'd1) begin
            cmp_word = inst_q;
        end
    end

    assign field_bad = fire && (exp_data != cmp_word);
    assign stop_now  = (STOP_ON_ERR != 0) && (mismatch_q || field_bad);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (commit_valid) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (last_fire) begin
                    state_d = (hit_limit || stop_now) ? S_DONE : S_IDLE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = (state_q == S_CHECK);
        exp_ready = (state_q == S_CHECK);
        rf_raddr  = 5'd0;
        if ((state_q == S_CHECK) && (field_q >= 6'd2)) begin
            rf_raddr = 5'(field_q - 6'd2);
        end
    end

    always_comb begin
        field_d    = field_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        rec_d      = rec_q;
        ferr_rec_d = ferr_rec_q;
        ferr_fld_d = ferr_fld_q;
        done_d     = done_q;

        if ((state_q == S_IDLE) && commit_valid) begin
            pc_d    = commit_pc;
            inst_d  = commit_inst;
            field_d = 6'd0;
        end

        if (fire) begin
            field_d = last_fire ? 6'd0 : field_q + 6'd1;
        end

        if (field_bad) begin
            mismatch_d = 1'b1;
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (!mismatch_q) begin
                ferr_rec_d = rec_q;
                ferr_fld_d = field_q;
            end
        end

        if (last_fire) begin
            rec_d = rec_inc;
            if (hit_limit || stop_now) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            field_q    <= 6'd0;
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
            mismatch_q <= 1'b0;
            err_q      <= 16'd0;
            rec_q      <= 16'd0;
            ferr_rec_q <= 16'd0;
            ferr_fld_q <= 6'd0;
            done_q     <= 1'b0;
        end else begin
            field_q    <= field_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            rec_q      <= rec_d;
            ferr_rec_q <= ferr_rec_d;
            ferr_fld_q <= ferr_fld_d;
            done_q     <= done_d;
        end
    end

    assign mismatch        = mismatch_q;
    assign err_count       = err_q;
    assign rec_count       = rec_q;
    assign first_err_rec   = ferr_rec_q;
    assign first_err_field = ferr_fld_q;
    assign done            = done_q;

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: vector table, hand sequences, random records
// against a record-level model, and a long saturation run in parallel.
`timescale 1ns/1ps
module tb_trace_checker;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset           [NI];
    logic        commit_valid    [NI];
    logic [31:0] commit_pc       [NI];
    logic [31:0] commit_inst     [NI];
    logic        cpu_stall       [NI];
    logic [4:0]  rf_raddr        [NI];
    logic [31:0] rf_rdata        [NI];
    logic        exp_valid       [NI];
    logic [31:0] exp_data        [NI];
    logic        exp_ready       [NI];
    logic        mismatch        [NI];
    logic [15:0] err_count       [NI];
    logic [15:0] rec_count       [NI];
    logic [15:0] first_err_rec   [NI];
    logic [5:0]  first_err_field [NI];
    logic        done            [NI];

    logic [31:0] rf   [NI][32];
    logic [31:0] wbuf [NI][34];

    int n_chk = 0;
    int n_fail = 0;

    // 0: defaults, 1: MAX_RECORDS=2, 2: STOP_ON_ERR=1, 3: saturation run
    for (genvar g = 0; g < NI; g++) begin : g_dut
        trace_checker #(
            .MAX_RECORDS(g == 1 ? 2 : (g == 3 ? 5000 : 1200)),
            .STOP_ON_ERR(g == 2 ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .reset(reset[g]),
            .commit_valid(commit_valid[g]),
            .commit_pc(commit_pc[g]),
            .commit_inst(commit_inst[g]),
            .cpu_stall(cpu_stall[g]),
            .rf_raddr(rf_raddr[g]),
            .rf_rdata(rf_rdata[g]),
            .exp_valid(exp_valid[g]),
            .exp_data(exp_data[g]),
            .exp_ready(exp_ready[g]),
            .mismatch(mismatch[g]),
            .err_count(err_count[g]),
            .rec_count(rec_count[g]),
            .first_err_rec(first_err_rec[g]),
            .first_err_field(first_err_field[g]),
            .done(done[g])
        );
        assign rf_rdata[g] = rf[g][rf_raddr[g]];
    end

    typedef struct {
        bit          rst;
        logic [31:0] pc;
        logic [31:0] inst;
        int          flip;
        logic [31:0] xm;
        int          gap;
        int          e_rec;
        int          e_err;
        int          e_mis;
        int          e_fer;
        int          e_fef;
        int          e_stall;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", n, act, exp);
        end
    endtask

    task automatic check_state(input int g, input string n, input int rec, input int err,
                               input int mis, input int fer, input int fef, input int dn);
        chk({n, ".rec_count"}, 32'(rec_count[g]), rec);
        chk({n, ".err_count"}, 32'(err_count[g]), err);
        chk({n, ".mismatch"}, 32'(mismatch[g]), mis);
        chk({n, ".first_err_rec"}, 32'(first_err_rec[g]), fer);
        chk({n, ".first_err_field"}, 32'(first_err_field[g]), fef);
        chk({n, ".done"}, 32'(done[g]), dn);
        chk({n, ".cpu_stall"}, 32'(cpu_stall[g]), 0);
        chk({n, ".exp_ready"}, 32'(exp_ready[g]), 0);
    endtask

    task automatic do_reset(input int g);
        reset[g] = 1'b0;
        commit_valid[g] = 1'b0;
        exp_valid[g] = 1'b1;
        exp_data[g] = $urandom;
        @(posedge clk);
        #1;
        reset[g] = 1'b1;
        exp_valid[g] = 1'b0;
    endtask

    task automatic build_words(input int g, input logic [31:0] pc, input logic [31:0] inst);
        wbuf[g][0] = pc;
        wbuf[g][1] = inst;
        for (int i = 0; i < 32; i++) wbuf[g][2 + i] = rf[g][i];
    endtask

    // gap: 0 = word every cycle, 1 = valid toggles 1,0,1,0, 2 = random
    task automatic run_record(input int g, input logic [31:0] pc, input logic [31:0] inst,
                              input int gap, output int ninv, output int stall);
        int idx;
        int cyc;
        bit v;
        bit acc;
        idx = 0;
        cyc = 0;
        ninv = 0;
        stall = 0;
        commit_valid[g] = 1'b1;
        commit_pc[g] = pc;
        commit_inst[g] = inst;
        @(posedge clk);
        #1;
        commit_valid[g] = 1'b0;
        commit_pc[g] = $urandom;
        commit_inst[g] = $urandom;
        while (idx < 34 && cyc < 400) begin
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = (cyc % 2 == 0);
            else v = ($urandom_range(0, 3) != 0);
            if (gap == 2) commit_valid[g] = 1'($urandom_range(0, 1));
            exp_valid[g] = v;
            exp_data[g] = v ? wbuf[g][idx] : $urandom;
            if (!v) ninv++;
            if (cpu_stall[g]) stall++;
            acc = v && exp_ready[g];
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        exp_valid[g] = 1'b0;
        commit_valid[g] = 1'b0;
        chk($sformatf("words_accepted[%0d]", g), idx, 34);
    endtask

    task automatic main_seq();
        vec_t tbl [8];
        int ninv;
        int stall;
        int m_rec, m_err, m_mis, m_fer, m_fef;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] a;
        int nbad;
        int ff;

        tbl[0] = '{1'b1, 32'h00400000, 32'h3c010040, -1, 32'h0,        0, 1, 0, 0, 0, 0, 34};
        tbl[1] = '{1'b1, 32'h00400008, 32'h8c220004,  7, 32'h1,        0, 1, 1, 1, 0, 7, 34};
        tbl[2] = '{1'b0, 32'h0040000c, 32'h00000000, -1, 32'h0,        0, 2, 1, 1, 0, 7, 34};
        tbl[3] = '{1'b0, 32'h00400010, 32'hac230008,  0, 32'h80000000, 1, 3, 2, 1, 0, 7, 67};
        tbl[4] = '{1'b1, 32'h00400000, 32'h3c010040, -1, 32'h0,        1, 1, 0, 0, 0, 0, 67};
        tbl[5] = '{1'b0, 32'h00400014, 32'h00000013,  2, 32'h1,        0, 2, 1, 1, 1, 2, 34};
        tbl[6] = '{1'b0, 32'h00400018, 32'h01000513, 33, 32'hFFFFFFFF, 1, 3, 2, 1, 1, 2, 67};
        tbl[7] = '{1'b0, 32'h0040001c, 32'h00a00593,  1, 32'h100,      0, 4, 3, 1, 1, 2, 34};

        do_reset(0);
        check_state(0, "reset", 0, 0, 0, 0, 0, 0);
        chk("reset.rf_raddr", 32'(rf_raddr[0]), 0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) do_reset(0);
            for (int r = 0; r < 32; r++) rf[0][r] = $urandom;
            build_words(0, tbl[i].pc, tbl[i].inst);
            if (tbl[i].flip >= 0) wbuf[0][tbl[i].flip] = wbuf[0][tbl[i].flip] ^ tbl[i].xm;
            run_record(0, tbl[i].pc, tbl[i].inst, tbl[i].gap, ninv, stall);
            check_state(0, $sformatf("tbl%0d", i), tbl[i].e_rec, tbl[i].e_err,
                        tbl[i].e_mis, tbl[i].e_fer, tbl[i].e_fef, 0);
            chk($sformatf("tbl%0d.stall_cycles", i), stall, tbl[i].e_stall);
        end

        // Reset after 10 accepted words abandons the record
        for (int r = 0; r < 32; r++) rf[0][r] = $urandom;
        build_words(0, 32'h00400020, 32'h00b00613);
        commit_valid[0] = 1'b1;
        commit_pc[0] = 32'h00400020;
        commit_inst[0] = 32'h00b00613;
        @(posedge clk);
        #1;
        commit_valid[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_valid[0] = 1'b1;
            exp_data[0] = wbuf[0][k];
            @(posedge clk);
            #1;
        end
        exp_valid[0] = 1'b0;
        chk("midrec.cpu_stall", 32'(cpu_stall[0]), 1);
        chk("midrec.rf_raddr", 32'(rf_raddr[0]), 8);
        do_reset(0);
        check_state(0, "midrec_reset", 0, 0, 0, 0, 0, 0);
        chk("midrec_reset.rf_raddr", 32'(rf_raddr[0]), 0);
        build_words(0, 32'h00400024, 32'h00c00693);
        run_record(0, 32'h00400024, 32'h00c00693, 0, ninv, stall);
        check_state(0, "after_midrec", 1, 0, 0, 0, 0, 0);

        // Random records against a record-level model
        do_reset(0);
        m_rec = 0; m_err = 0; m_mis = 0; m_fer = 0; m_fef = 0;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                chk("rand.idle_stall", 32'(cpu_stall[0]), 0);
            end
            pc = $urandom;
            inst = $urandom;
            for (int r = 0; r < 32; r++) rf[0][r] = $urandom;
            build_words(0, pc, inst);
            for (int f = 0; f < 34; f++)
                if ($urandom_range(0, 19) == 0) wbuf[0][f] = wbuf[0][f] ^ ($urandom | 32'h1);
            nbad = 0;
            ff = -1;
            for (int f = 0; f < 34; f++) begin
                if (f == 0) a = pc;
                else if (f == 1) a = inst;
                else a = rf[0][f - 2];
                if (wbuf[0][f] != a) begin
                    nbad++;
                    if (ff < 0) ff = f;
                end
            end
            run_record(0, pc, inst, 2, ninv, stall);
            if (nbad > 0 && m_mis == 0) begin
                m_fer = m_rec;
                m_fef = ff;
            end
            if (nbad > 0) m_mis = 1;
            m_err = (m_err + nbad > 65535) ? 65535 : m_err + nbad;
            m_rec = (m_rec + 1) % 65536;
            check_state(0, $sformatf("rand%0d", i), m_rec, m_err, m_mis, m_fer, m_fef, 0);
            chk($sformatf("rand%0d.stall_cycles", i), stall, 34 + ninv);
        end

        // Record limit of 2, then a commit that must be ignored
        do_reset(1);
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 32; r++) rf[1][r] = $urandom;
            build_words(1, 32'h00400000 + 32'(i * 4), 32'h3c010040);
            run_record(1, 32'h00400000 + 32'(i * 4), 32'h3c010040, 0, ninv, stall);
            check_state(1, $sformatf("lim%0d", i), i + 1, 0, 0, 0, 0, (i == 1) ? 1 : 0);
        end
        commit_valid[1] = 1'b1;
        commit_pc[1] = 32'h00400100;
        commit_inst[1] = 32'h3c010040;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("lim.ignored.cpu_stall", 32'(cpu_stall[1]), 0);
            chk("lim.ignored.exp_ready", 32'(exp_ready[1]), 0);
        end
        commit_valid[1] = 1'b0;
        check_state(1, "lim.after", 2, 0, 0, 0, 0, 1);

        // Stop on error found in the last field of record 0
        do_reset(2);
        for (int r = 0; r < 32; r++) rf[2][r] = $urandom;
        build_words(2, 32'h00400000, 32'h3c010040);
        wbuf[2][33] = wbuf[2][33] ^ 32'h00010000;
        run_record(2, 32'h00400000, 32'h3c010040, 0, ninv, stall);
        check_state(2, "stop", 1, 1, 1, 0, 33, 1);
        commit_valid[2] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stop.ignored.cpu_stall", 32'(cpu_stall[2]), 0);
        end
        commit_valid[2] = 1'b0;
        check_state(2, "stop.after", 1, 1, 1, 0, 33, 1);
    endtask

    // 2059 records x 34 wrong fields = 70006 mismatches
    task automatic sat_seq();
        int ninv;
        int stall;
        do_reset(3);
        for (int r = 0; r < 32; r++) rf[3][r] = $urandom;
        for (int i = 0; i < 2059; i++) begin
            build_words(3, 32'h00400000 + 32'(i * 4), 32'h00000013);
            for (int f = 0; f < 34; f++) wbuf[3][f] = ~wbuf[3][f];
            run_record(3, 32'h00400000 + 32'(i * 4), 32'h00000013, 0, ninv, stall);
            if (i == 999) chk("sat.err_count_mid", 32'(err_count[3]), 34000);
        end
        check_state(3, "sat", 2059, 65535, 1, 0, 0, 0);
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            reset[g] = 1'b0;
            commit_valid[g] = 1'b0;
            commit_pc[g] = 32'd0;
            commit_inst[g] = 32'd0;
            exp_valid[g] = 1'b0;
            exp_data[g] = 32'd0;
            for (int r = 0; r < 32; r++) rf[g][r] = 32'd0;
        end
        @(posedge clk);
        #1;
        fork
            main_seq();
            sat_seq();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter MAX_RECORDS, default 1200; number of commit records checked before entering DONE.
REQ-002 Parameter STOP_ON_ERR, default 0; when 1, the record containing the first mismatch is the last record checked.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 commit_valid  in  1  CPU retires one instruction this cycle; its regfile write lands on this rising edge.
REQ-006 commit_pc  in  32  PC of the retiring instruction.
REQ-007 commit_inst  in  32  instruction word of the retiring instruction.
REQ-008 cpu_stall  out  1  freezes CPU PC and regfile writes while high.
REQ-009 rf_raddr  out  5  regfile debug read address.
REQ-010 rf_rdata  in  32  regfile debug read data, combinational from rf_raddr.
REQ-011 exp_valid  in  1  expected-trace word available.
REQ-012 exp_data  in  32  expected-trace word; per record, in order: pc, inst, reg0..reg31 (34 words).
REQ-013 exp_ready  out  1  checker accepts exp_data this cycle.
REQ-014 mismatch  out  1  sticky; any field has mismatched since reset.
REQ-015 err_count  out  16  count of mismatched fields, saturating.
REQ-016 rec_count  out  16  count of fully checked records.
REQ-017 first_err_rec  out  16  rec_count value of the first mismatch.
REQ-018 first_err_field  out  6  field of the first mismatch: 0=pc, 1=inst, 2..33=reg0..reg31.
REQ-019 done  out  1  sticky; checking finished.

Function
REQ-020 States: IDLE, CHECK, DONE; cpu_stall = (state==CHECK), decoded from registered state only.
REQ-021 IDLE: exp_ready=0; on commit_valid=1, latch commit_pc/commit_inst, clear field index to 0, go to CHECK.
REQ-022 CHECK: exp_ready=1; rf_raddr = field-2 for field>=2, else 0.
REQ-023 Field advances only on exp_valid&&exp_ready; with exp_valid=0 the FSM holds with no state change.
REQ-024 Compare: field 0 vs latched pc, field 1 vs latched inst, fields 2..33 vs rf_rdata; compare is full 32-bit equality.
REQ-025 On mismatch: mismatch<=1; err_count+1, saturating at 16'hFFFF; on the first mismatch only, capture first_err_rec and first_err_field.
REQ-026 On the field-33 handshake: rec_count+1, wrapping at 16 bits.
REQ-026a After field 33, go to DONE if the new rec_count==MAX_RECORDS, or if STOP_ON_ERR=1 and mismatch (including this record); otherwise go to IDLE.
REQ-027 Minimum record latency is 34 CHECK cycles, giving one commit accepted per 35 cycles at best; commit_valid during CHECK cannot occur, because the CPU is stalled, and is ignored.
REQ-028 DONE: done=1, cpu_stall=0, exp_ready=0, commits ignored; exit only by reset.
REQ-029 Reg0 is compared like any other register, with no special-casing.

Reset
REQ-030 reset=0 at a rising edge: state<=IDLE, field<=0; latched pc/inst, mismatch, err_count, rec_count, first_err_rec, first_err_field and done all <=0.
REQ-030a Consequently, cpu_stall=0, exp_ready=0 and rf_raddr=0 after that edge.
REQ-031 Reset mid-CHECK abandons the partial record; no counter update occurs, and no expected words are consumed during reset.

Verification
REQ-032 Matching record: commit pc=0x00400000 inst=0x3c010040; expected stream equal with exp_valid held 1 -> cpu_stall high exactly 34 cycles, rec_count=1, err_count=0, mismatch=0.
REQ-033 Single-field error: expected reg5 word = actual^1 -> err_count=1, mismatch=1, first_err_rec=0, first_err_field=7; a following correct record leaves first_err_* unchanged.
REQ-034 Backpressure: exp_valid toggles 1,0,1,0 -> one field per valid cycle, cpu_stall held until the 34th accepted word, result identical to the continuous case.
REQ-035 Limit/stop: MAX_RECORDS=2 -> done=1 after the 2nd record and a 3rd commit is ignored with cpu_stall=0; STOP_ON_ERR=1 with error in record 0 -> done=1 after that record, rec_count=1.
REQ-036 Reset mid-record: reset=0 after 10 accepted words -> all outputs 0 next cycle; a fresh record afterward checks cleanly with rec_count=1.
REQ-037 Saturation: force 70000 mismatched fields -> err_count stays 16'hFFFF.
